axi_sram_read_slave: RTL and testbench
======================================

// Module: axi_sram_read_slave
// PURPOSE
//  AXI read responder at the slave end of the interconnect AR/R path.
//  Accepts one read-address transfer at a time from the bridge and fetches
//  each beat from a synchronous single-port SRAM. Returns the burst on the
//  R channel with RID, RRESP and RLAST. Sits between the interconnect slave
//  port (S0/S1) and the SRAM macro.
// PARAMETERS
//  IDS_W   8   AR/R ID width; equals `AXI_IDS_BITS (master tag + ID)
//  ADDR_W  32  AR address width, `AXI_ADDR_BITS
//  DATA_W  32  R data width, `AXI_DATA_BITS
//  LEN_W   4   ARLEN width, `AXI_LEN_BITS
//  MEM_AW  14  SRAM word-address width (the array holds 2^MEM_AW words)
// PORTS
//  clk         in   1       clock, rising edge
//  rst         in   1       asynchronous, active-low reset
//  ARID_S      in   IDS_W   read ID
//  ARADDR_S    in   ADDR_W  byte address of first beat
//  ARLEN_S     in   LEN_W   beats-1
//  ARSIZE_S    in   3       beat size; only 3'b010 (4 B) is legal
//  ARBURST_S   in   2       00 FIXED, 01 INCR; others are illegal
//  ARVALID_S   in   1       AR valid
//  ARREADY_S   out  1       AR ready (registered)
//  RID_S       out  IDS_W   ID echoed from the accepted AR
//  RDATA_S     out  DATA_W  read data
//  RRESP_S     out  2       00 OKAY, 10 SLVERR
//  RLAST_S     out  1       final beat of the burst
//  RVALID_S    out  1       R valid
//  RREADY_S    in   1       R ready from the interconnect
//  sram_cs     out  1       SRAM chip select
//  sram_oe     out  1       SRAM output enable
//  sram_a      out  MEM_AW  SRAM word address
//  sram_do     in   DATA_W  SRAM read data; valid the cycle after cs/a are sampled
// BEHAVIOUR
//  - Reset (rst=0, async): state IDLE; ARREADY_S=0; all R outputs and SRAM
//    outputs are 0; beat counter, ID, address and error registers are 0.
//    Reset mid-burst abandons the burst with no further R beats.
//  - ARREADY_S is set the first cycle after reset release and on each return
//    to IDLE. It is cleared on the AR handshake. It is never 1 outside IDLE.
//  - FSM: IDLE -> FETCH -> LOAD -> SEND
//    - IDLE: on ARVALID_S&ARREADY_S, latch ID, ARADDR_S[MEM_AW+1:2], LEN
//      and err. err = (ARSIZE_S!=3'b010) | (ARBURST_S[1]==1). Go to FETCH.
//    - FETCH: sram_cs=sram_oe=1, sram_a=addr_q. Go to LOAD.
//    - LOAD: capture sram_do into rdata_q. Go to SEND.
//    - SEND: RVALID_S=1. RDATA_S=rdata_q, or 0 when err. RRESP_S = err ? 10 : 00.
//      RLAST_S=(beat_cnt==len_q). All R outputs stay stable until RREADY_S.
//      On RVALID_S&RREADY_S:
//        - not last: beat_cnt++, addr_q += (INCR ? 1 : 0), go to FETCH.
//        - last: go to IDLE and set ARREADY_S.
//  - Latency: AR handshake at edge N gives the first RVALID_S in cycle N+3.
//    Each further beat adds 3 cycles after its predecessor's R handshake.
//  - An erroneous burst still returns exactly LEN+1 beats with SLVERR. SRAM
//    is not accessed for it (cs=oe=0 in FETCH).
//  - addr_q increments modulo 2^MEM_AW (word address wraps to 0).
//    beat_cnt is LEN_W bits wide; ARLEN=15 gives 16 beats.
//  - ARVALID_S while busy: ARREADY_S=0; the AR is held off until IDLE.
//  - RREADY_S low for any number of cycles stalls in SEND with no SRAM access.
// CONFIGURATION
//  - `RS_4KB_CHECK_EN defined: in IDLE, an INCR burst with
//    ARADDR_S[11:0] + 4*(ARLEN_S+1) > 4096 also sets err. The whole burst is
//    then SLVERR.
//  - Not defined: no boundary check. Addresses simply increment and wrap per
//    the rule above.
// TESTING
//  1 AR id=8'h12 addr=0x10 len=0 INCR, SRAM[4]=0xDEADBEEF, RREADY=1
//    -> RVALID 3 cycles after the handshake; RDATA=DEADBEEF, RID=12,
//    RLAST=1, OKAY; ARREADY back to 1.
//  2 AR addr=0x0 len=3 INCR, RREADY low 5 cycles on beat 1
//    -> beats return SRAM[0..3] in order; beat 1 held stable while stalled;
//    RLAST only on beat 3.
//  3 AR addr=0x8 len=2 FIXED -> three beats, each equal to SRAM[2]; RLAST on the third.
//  4 AR ARBURST=2'b10 len=1 (also ARSIZE=3'b001)
//    -> two beats with RRESP=10 and RDATA=0; sram_cs never asserted.
//  5 rst low while in SEND on beat 2 of 4
//    -> all outputs 0 immediately; after release ARREADY=1 next cycle and no stale R beat.
//  6 `RS_4KB_CHECK_EN: AR addr=0xFF8 len=3 INCR -> 4x SLVERR.
//    Without the macro -> 4x OKAY from words 0x3FE..0x401.

Source files
------------

// File: rtl/axi_sram_read_slave.sv
// AXI read responder: accepts one AR burst at a time, fetches each beat from a
// synchronous single-port SRAM and returns it on R. `RS_4KB_CHECK_EN adds a 4 KB boundary check.
module axi_sram_read_slave #(
    parameter int IDS_W  = 8,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 4,
    parameter int MEM_AW = 14
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [IDS_W-1:0]  ARID_S,
    input  logic [ADDR_W-1:0] ARADDR_S,
    input  logic [LEN_W-1:0]  ARLEN_S,
    input  logic [2:0]        ARSIZE_S,
    input  logic [1:0]        ARBURST_S,
    input  logic              ARVALID_S,
    output logic              ARREADY_S,
    output logic [IDS_W-1:0]  RID_S,
    output logic [DATA_W-1:0] RDATA_S,
    output logic [1:0]        RRESP_S,
    output logic              RLAST_S,
    output logic              RVALID_S,
    input  logic              RREADY_S,
    output logic              sram_cs,
    output logic              sram_oe,
    output logic [MEM_AW-1:0] sram_a,
    input  logic [DATA_W-1:0] sram_do
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_LOAD  = 2'd2,
        ST_SEND  = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic               arready_q, arready_d;
    logic [IDS_W-1:0]   id_q, id_d;
    logic [MEM_AW-1:0]  addr_q, addr_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [LEN_W-1:0]   beat_q, beat_d;
    logic               err_q, err_d;
    logic               incr_q, incr_d;
    logic [DATA_W-1:0]  rdata_q, rdata_d;
    logic [1:0]         rresp_q, rresp_d;
    logic               rlast_q, rlast_d;
    logic               rvalid_q, rvalid_d;
    logic               sram_cs_q, sram_cs_d;
    logic               sram_oe_q, sram_oe_d;
    logic [MEM_AW-1:0]  sram_a_q, sram_a_d;
    logic               ar_err_s;
    logic               unused_addr_s;

    // Decode an illegal AR request (bad size, reserved burst type, optional 4 KB crossing)
`ifdef RS_4KB_CHECK_EN
    logic [12:0] bnd_end_s;
    always_comb begin
        bnd_end_s = {1'b0, ARADDR_S[11:0]}
                  + {{(13-LEN_W-2){1'b0}}, ARLEN_S, 2'b00}
                  + 13'd4;
        ar_err_s  = (ARSIZE_S != 3'b010) || ARBURST_S[1]
                  || ((ARBURST_S == 2'b01) && (bnd_end_s > 13'd4096));
    end
`else
    always_comb begin
        ar_err_s = (ARSIZE_S != 3'b010) || ARBURST_S[1];
    end
`endif

    // Byte-lane and high address bits are not needed for a word-addressed SRAM
    assign unused_addr_s = ^{ARADDR_S[ADDR_W-1:MEM_AW+2], ARADDR_S[1:0]};

    // Next-state and datapath computation for the burst sequencer
    always_comb begin
        state_d  = state_q;
        id_d     = id_q;
        addr_d   = addr_q;
        len_d    = len_q;
        beat_d   = beat_q;
        err_d    = err_q;
        incr_d   = incr_q;
        rdata_d  = rdata_q;
        rresp_d  = rresp_q;
        rlast_d  = rlast_q;

        case (state_q)
            ST_IDLE: begin
                if (ARVALID_S && arready_q) begin
                    id_d    = ARID_S;
                    addr_d  = ARADDR_S[MEM_AW+1:2];
                    len_d   = ARLEN_S;
                    beat_d  = {LEN_W{1'b0}};
                    err_d   = ar_err_s;
                    incr_d  = (ARBURST_S == 2'b01);
                    state_d = ST_FETCH;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_FETCH: begin
                state_d = ST_LOAD;
            end
            ST_LOAD: begin
                // Error bursts never touch the SRAM, so sram_do is meaningless here
                rdata_d = err_q ? {DATA_W{1'b0}} : sram_do;
                rresp_d = err_q ? 2'b10 : 2'b00;
                rlast_d = (beat_q == len_q);
                state_d = ST_SEND;
            end
            ST_SEND: begin
                if (RREADY_S) begin
                    if (rlast_q) begin
                        state_d = ST_IDLE;
                    end else begin
                        beat_d  = beat_q + {{(LEN_W-1){1'b0}}, 1'b1};
                        addr_d  = addr_q + {{(MEM_AW-1){1'b0}}, incr_q};
                        state_d = ST_FETCH;
                    end
                end else begin
                    state_d = ST_SEND;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Registered handshake and SRAM strobes derived from the upcoming state
    always_comb begin
        arready_d = (state_d == ST_IDLE);
        rvalid_d  = (state_d == ST_SEND);
        sram_cs_d = (state_d == ST_FETCH) && !err_d;
        sram_oe_d = sram_cs_d;
        if (sram_cs_d) begin
            sram_a_d = addr_d;
        end else begin
            sram_a_d = {MEM_AW{1'b0}};
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            arready_q <= 1'b0;
            id_q      <= {IDS_W{1'b0}};
            addr_q    <= {MEM_AW{1'b0}};
            len_q     <= {LEN_W{1'b0}};
            beat_q    <= {LEN_W{1'b0}};
            err_q     <= 1'b0;
            incr_q    <= 1'b0;
            rdata_q   <= {DATA_W{1'b0}};
            rresp_q   <= 2'b00;
            rlast_q   <= 1'b0;
            rvalid_q  <= 1'b0;
            sram_cs_q <= 1'b0;
            sram_oe_q <= 1'b0;
            sram_a_q  <= {MEM_AW{1'b0}};
        end else begin
            state_q   <= state_d;
            arready_q <= arready_d;
            id_q      <= id_d;
            addr_q    <= addr_d;
            len_q     <= len_d;
            beat_q    <= beat_d;
            err_q     <= err_d;
            incr_q    <= incr_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
            rlast_q   <= rlast_d;
            rvalid_q  <= rvalid_d;
            sram_cs_q <= sram_cs_d;
            sram_oe_q <= sram_oe_d;
            sram_a_q  <= sram_a_d;
        end
    end

    assign ARREADY_S = arready_q;
    assign RID_S     = id_q;
    assign RDATA_S   = rdata_q;
    assign RRESP_S   = rresp_q;
    assign RLAST_S   = rlast_q;
    assign RVALID_S  = rvalid_q;
    assign sram_cs   = sram_cs_q;
    assign sram_oe   = sram_oe_q;
    assign sram_a    = sram_a_q;

endmodule

// File: tb/tb_axi_sram_read_slave.sv
// Randomized bench for axi_sram_read_slave with a behavioural SRAM and a
// burst-level reference model (beat list, latency, response, SRAM access count).
module tb_axi_sram_read_slave;
    localparam int IDS_W  = 8;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int LEN_W  = 4;
    localparam int MEM_AW = 14;

    logic              clk = 1'b0;
    logic              rst;
    logic [IDS_W-1:0]  ARID_S;
    logic [ADDR_W-1:0] ARADDR_S;
    logic [LEN_W-1:0]  ARLEN_S;
    logic [2:0]        ARSIZE_S;
    logic [1:0]        ARBURST_S;
    logic              ARVALID_S;
    logic              ARREADY_S;
    logic [IDS_W-1:0]  RID_S;
    logic [DATA_W-1:0] RDATA_S;
    logic [1:0]        RRESP_S;
    logic              RLAST_S;
    logic              RVALID_S;
    logic              RREADY_S;
    logic              sram_cs;
    logic              sram_oe;
    logic [MEM_AW-1:0] sram_a;
    logic [DATA_W-1:0] sram_do = '0;

    logic [DATA_W-1:0] mem [0:(1<<MEM_AW)-1];
    int cs_total = 0;
    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    axi_sram_read_slave #(
        .IDS_W(IDS_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W), .MEM_AW(MEM_AW)
    ) dut (
        .clk(clk), .rst(rst),
        .ARID_S(ARID_S), .ARADDR_S(ARADDR_S), .ARLEN_S(ARLEN_S), .ARSIZE_S(ARSIZE_S),
        .ARBURST_S(ARBURST_S), .ARVALID_S(ARVALID_S), .ARREADY_S(ARREADY_S),
        .RID_S(RID_S), .RDATA_S(RDATA_S), .RRESP_S(RRESP_S), .RLAST_S(RLAST_S),
        .RVALID_S(RVALID_S), .RREADY_S(RREADY_S),
        .sram_cs(sram_cs), .sram_oe(sram_oe), .sram_a(sram_a), .sram_do(sram_do)
    );

    // Synchronous SRAM: data appears the cycle after the strobe is sampled
    always @(posedge clk) begin
        if (sram_cs && sram_oe) sram_do <= mem[sram_a];
        if (sram_cs) cs_total <= cs_total + 1;
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic bit model_err(input logic [31:0] addr, input logic [3:0] len,
                                     input logic [2:0] size, input logic [1:0] burst);
        bit e;
        e = (size != 3'b010) || (burst == 2'b10) || (burst == 2'b11);
`ifdef RS_4KB_CHECK_EN
        if (burst == 2'b01 && (int'(addr[11:0]) + 4 * (int'(len) + 1) > 4096)) e = 1'b1;
`endif
        return e;
    endfunction

    function automatic logic [63:0] all_outputs();
        return {3'b000, ARREADY_S, RID_S, RDATA_S, RRESP_S, RLAST_S, RVALID_S,
                sram_cs, sram_oe, sram_a};
    endfunction

    task automatic run_burst(input logic [7:0] id, input logic [31:0] addr, input logic [3:0] len,
                             input logic [2:0] size, input logic [1:0] burst,
                             input int stall_beat, input int stall_len, input bit rnd_stall,
                             input int abort_beat);
        bit err;
        int k, s, cs0;
        logic [13:0] base_w, w;
        logic [31:0] exp_d;
        err    = model_err(addr, len, size, burst);
        base_w = addr[15:2];
        @(negedge clk);
        ARID_S = id; ARADDR_S = addr; ARLEN_S = len; ARSIZE_S = size; ARBURST_S = burst;
        ARVALID_S = 1'b1;
        k = 0;
        while (!ARREADY_S && k < 50) begin
            @(negedge clk);
            k++;
        end
        check_val("ar_ready", ARREADY_S, 1'b1);
        cs0 = cs_total;
        for (int i = 0; i <= int'(len); i++) begin
            k = 0;
            do begin
                @(negedge clk);
                k++;
                RREADY_S = 1'b0;
                if (k == 1 && i == 0) begin
                    check_val("ar_clr", ARREADY_S, 1'b0);
                    ARVALID_S = 1'b0;
                end
            end while (!RVALID_S && k < 12);
            check_val("lat", k, 3);
            if (i == abort_beat) begin
                rst = 1'b0;
                #1;
                check_val("rst_out", all_outputs(), 64'd0);
                @(negedge clk);
                rst = 1'b1;
                @(negedge clk);
                check_val("rst_arready", ARREADY_S, 1'b1);
                repeat (4) begin
                    @(negedge clk);
                    check_val("no_stale", RVALID_S, 1'b0);
                end
                return;
            end
            w     = (burst == 2'b01) ? 14'(base_w + 14'(i)) : base_w;
            exp_d = err ? 32'd0 : mem[w];
            s     = (i == stall_beat) ? stall_len : (rnd_stall ? int'($urandom_range(0, 2)) : 0);
            for (int j = 0; j <= s; j++) begin
                if (j > 0) @(negedge clk);
                check_val("rvalid", RVALID_S, 1'b1);
                check_val("rdata", RDATA_S, exp_d);
                check_val("rresp", RRESP_S, err ? 2'b10 : 2'b00);
                check_val("rlast", RLAST_S, (i == int'(len)));
                check_val("rid", RID_S, id);
                check_val("busy_arready", ARREADY_S, 1'b0);
                if (j < s) check_val("stall_cs", sram_cs, 1'b0);
            end
            RREADY_S = 1'b1;
        end
        @(negedge clk);
        RREADY_S = 1'b0;
        check_val("end_arready", ARREADY_S, 1'b1);
        check_val("end_rvalid", RVALID_S, 1'b0);
        check_val("cs_cnt", cs_total - cs0, err ? 0 : int'(len) + 1);
    endtask

    initial begin
        #3000000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        logic [31:0] a;
        logic [2:0]  sz;
        for (int i = 0; i < (1 << MEM_AW); i++) mem[i] = $urandom;
        mem[4] = 32'hDEADBEEF;
        rst = 1'b0; RREADY_S = 1'b0; ARVALID_S = 1'b0;
        ARID_S = '0; ARADDR_S = '0; ARLEN_S = '0; ARSIZE_S = '0; ARBURST_S = '0;
        repeat (3) @(negedge clk);
        check_val("reset_out", all_outputs(), 64'd0);
        rst = 1'b1;
        @(negedge clk);
        check_val("reset_arready", ARREADY_S, 1'b1);

        run_burst(8'h12, 32'h10, 4'd0, 3'b010, 2'b01, -1, 0, 1'b0, -1);
        run_burst(8'h34, 32'h0,  4'd3, 3'b010, 2'b01, 1, 5, 1'b0, -1);
        run_burst(8'h56, 32'h8,  4'd2, 3'b010, 2'b00, -1, 0, 1'b0, -1);
        run_burst(8'h78, 32'h20, 4'd1, 3'b001, 2'b10, -1, 0, 1'b0, -1);
        run_burst(8'h9A, 32'h40, 4'd3, 3'b010, 2'b01, -1, 0, 1'b0, 2);
        run_burst(8'hBC, 32'hFF8, 4'd3, 3'b010, 2'b01, -1, 0, 1'b0, -1);
        run_burst(8'hDE, 32'hFFF8, 4'd3, 3'b010, 2'b01, -1, 0, 1'b0, -1);
        run_burst(8'hF0, 32'h100, 4'd15, 3'b010, 2'b01, 15, 3, 1'b1, -1);
        run_burst(8'h01, 32'h104, 4'd1, 3'b010, 2'b11, -1, 0, 1'b0, -1);

        for (int n = 0; n < 40; n++) begin
            a  = $urandom;
            sz = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(0, 7)) : 3'b010;
            run_burst(8'($urandom), a, 4'($urandom_range(0, 15)), sz,
                      2'($urandom_range(0, 3)), -1, 0, 1'b1, -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
